// File: rtl/rps_match_if.sv
// rtl/rps_match_if.sv - round request / result bundle for the rps_match controller
//
// Ports carried (direction as seen by the controller, modport slave):
//   new_match     in   synchronous match clear pulse
//   play_valid    in   round request
//   a_move        in   player A move, one-hot rock/paper/scissors
//   b_move        in   player B move, same encoding
//   play_ready    out  controller can take a round this cycle
//   result_valid  out  one-cycle pulse marking round_result fresh
//   round_result  out  00 tie, 10 A wins, 01 B wins, 11 invalid move
//   a_score       out  player A rounds won
//   b_score       out  player B rounds won
//   round_cnt     out  counted rounds (ties plus decisive rounds)
//   match_done    out  match finished
//   winner        out  10 A, 01 B, 00 draw / not done
interface rps_match_if #(
  parameter int CNT_W = 4
);
  logic             new_match;
  logic             play_valid;
  logic [2:0]       a_move;
  logic [2:0]       b_move;
  logic             play_ready;
  logic             result_valid;
  logic [1:0]       round_result;
  logic [CNT_W-1:0] a_score;
  logic [CNT_W-1:0] b_score;
  logic [CNT_W-1:0] round_cnt;
  logic             match_done;
  logic [1:0]       winner;

  modport master (
    output new_match,
    output play_valid,
    output a_move,
    output b_move,
    input  play_ready,
    input  result_valid,
    input  round_result,
    input  a_score,
    input  b_score,
    input  round_cnt,
    input  match_done,
    input  winner
  );

  modport slave (
    input  new_match,
    input  play_valid,
    input  a_move,
    input  b_move,
    output play_ready,
    output result_valid,
    output round_result,
    output a_score,
    output b_score,
    output round_cnt,
    output match_done,
    output winner
  );
endinterface

// File: rtl/rps_match.sv
// rtl/rps_match.sv - registered best-of-N rock-paper-scissors match controller
//
// Ports:
//   clk   in   clock, all state moves on the rising edge
//   rst   in   asynchronous active-high reset, returns to PLAY with cleared counts
//   bus   slave side of rps_match_if (round handshake in, scores/result/winner out)
//
// Parameters:
//   WIN_ROUNDS  score that wins the match
//   MAX_ROUNDS  counted rounds after which an undecided match is a draw
//   CNT_W       width of the score and round counters
module rps_match #(
  parameter int WIN_ROUNDS = 2,
  parameter int MAX_ROUNDS = 9,
  parameter int CNT_W      = 4
) (
  input  logic      clk,
  input  logic      rst,
  rps_match_if.slave bus
);

  typedef enum logic [0:0] {
    PLAY = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] WIN_C = CNT_W'(WIN_ROUNDS);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_ROUNDS);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  localparam logic [2:0] ROCK     = 3'b100;
  localparam logic [2:0] PAPER    = 3'b010;
  localparam logic [2:0] SCISSORS = 3'b001;

  localparam logic [1:0] RES_TIE     = 2'b00;
  localparam logic [1:0] RES_A       = 2'b10;
  localparam logic [1:0] RES_B       = 2'b01;
  localparam logic [1:0] RES_INVALID = 2'b11;

  state_t           state, state_n;
  logic [CNT_W-1:0] a_score_q, a_score_n;
  logic [CNT_W-1:0] b_score_q, b_score_n;
  logic [CNT_W-1:0] round_cnt_q, round_cnt_n;
  logic [1:0]       round_result_q, round_result_n;
  logic [1:0]       winner_q, winner_n;
  logic             result_valid_q, result_valid_n;
  logic             play_ready_q;
  logic             match_done_q;

  logic             a_ok;
  logic             b_ok;
  logic             a_beats_b;
  logic             b_beats_a;
  logic             accept;

  function automatic logic is_one_hot(input logic [2:0] m);
    return (m == ROCK) || (m == PAPER) || (m == SCISSORS);
  endfunction

  // Per-round decode; only meaningful when both moves are one-hot.
  always_comb begin
    a_ok      = is_one_hot(bus.a_move);
    b_ok      = is_one_hot(bus.b_move);
    a_beats_b = ((bus.a_move == ROCK)     && (bus.b_move == SCISSORS)) ||
                ((bus.a_move == PAPER)    && (bus.b_move == ROCK))     ||
                ((bus.a_move == SCISSORS) && (bus.b_move == PAPER));
    b_beats_a = ((bus.b_move == ROCK)     && (bus.a_move == SCISSORS)) ||
                ((bus.b_move == PAPER)    && (bus.a_move == ROCK))     ||
                ((bus.b_move == SCISSORS) && (bus.a_move == PAPER));
  end

  // new_match wins over a simultaneous request, so the round is dropped.
  assign accept = bus.play_valid && !bus.new_match && (state == PLAY);

  always_comb begin
    state_n        = state;
    a_score_n      = a_score_q;
    b_score_n      = b_score_q;
    round_cnt_n    = round_cnt_q;
    round_result_n = round_result_q;
    winner_n       = winner_q;
    result_valid_n = 1'b0;

    if (bus.new_match) begin
      state_n        = PLAY;
      a_score_n      = '0;
      b_score_n      = '0;
      round_cnt_n    = '0;
      round_result_n = RES_TIE;
      winner_n       = 2'b00;
    end else if (accept) begin
      result_valid_n = 1'b1;
      if (!(a_ok && b_ok)) begin
        // Invalid rounds are reported but never counted.
        round_result_n = RES_INVALID;
      end else begin
        round_cnt_n = round_cnt_q + ONE_C;
        if (a_beats_b) begin
          a_score_n      = a_score_q + ONE_C;
          round_result_n = RES_A;
        end else if (b_beats_a) begin
          b_score_n      = b_score_q + ONE_C;
          round_result_n = RES_B;
        end else begin
          round_result_n = RES_TIE;
        end

        // End-of-match check on the updated counts; a win on the last
        // counted round takes precedence over the draw.
        if (a_score_n == WIN_C) begin
          state_n  = DONE;
          winner_n = 2'b10;
        end else if (b_score_n == WIN_C) begin
          state_n  = DONE;
          winner_n = 2'b01;
        end else if (round_cnt_n == MAX_C) begin
          state_n  = DONE;
          winner_n = 2'b00;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= PLAY;
      a_score_q      <= '0;
      b_score_q      <= '0;
      round_cnt_q    <= '0;
      round_result_q <= RES_TIE;
      winner_q       <= 2'b00;
      result_valid_q <= 1'b0;
      play_ready_q   <= 1'b1;
      match_done_q   <= 1'b0;
    end else begin
      state          <= state_n;
      a_score_q      <= a_score_n;
      b_score_q      <= b_score_n;
      round_cnt_q    <= round_cnt_n;
      round_result_q <= round_result_n;
      winner_q       <= winner_n;
      result_valid_q <= result_valid_n;
      play_ready_q   <= (state_n == PLAY);
      match_done_q   <= (state_n == DONE);
    end
  end

  assign bus.play_ready   = play_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.round_result = round_result_q;
  assign bus.a_score      = a_score_q;
  assign bus.b_score      = b_score_q;
  assign bus.round_cnt    = round_cnt_q;
  assign bus.match_done   = match_done_q;
  assign bus.winner       = winner_q;

endmodule

// File: tb/tb_rps_match.sv
// tb/tb_rps_match.sv - bench for rps_match with a rules-level match model
module tb_rps_match;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  rps_match_if #(.CNT_W(4)) if0 ();
  rps_match_if #(.CNT_W(4)) if1 ();

  rps_match #(.WIN_ROUNDS(2), .MAX_ROUNDS(9), .CNT_W(4)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  rps_match #(.WIN_ROUNDS(2), .MAX_ROUNDS(3), .CNT_W(4)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int win_r [2] = '{2, 2};
  int max_r [2] = '{9, 3};

  int m_a   [2];
  int m_b   [2];
  int m_c   [2];
  int m_res [2];
  int m_win [2];
  bit m_done[2];
  bit m_rv  [2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int s = 0; s < 2; s++) begin
      m_a[s] = 0; m_b[s] = 0; m_c[s] = 0;
      m_res[s] = 0; m_win[s] = 0;
      m_done[s] = 0; m_rv[s] = 0;
    end
  endtask

  // Moves as indices rock=0, paper=1, scissors=2: A beats B when (A-B) mod 3 == 1.
  function automatic int move_idx(input logic [2:0] m);
    if (m == 3'b100) return 0;
    if (m == 3'b010) return 1;
    return 2;
  endfunction

  task automatic model_step(input int s, input bit nm, input bit pv,
                            input logic [2:0] a, input logic [2:0] b);
    int d;
    m_rv[s] = 0;
    if (nm) begin
      m_a[s] = 0; m_b[s] = 0; m_c[s] = 0;
      m_res[s] = 0; m_win[s] = 0; m_done[s] = 0;
    end else if (pv && !m_done[s]) begin
      m_rv[s] = 1;
      if ($countones(a) != 1 || $countones(b) != 1) begin
        m_res[s] = 3;
      end else begin
        d = (move_idx(a) - move_idx(b) + 3) % 3;
        m_c[s]++;
        if (d == 1) begin m_a[s]++; m_res[s] = 2; end
        else if (d == 2) begin m_b[s]++; m_res[s] = 1; end
        else m_res[s] = 0;
        if (m_a[s] == win_r[s]) begin m_done[s] = 1; m_win[s] = 2; end
        else if (m_b[s] == win_r[s]) begin m_done[s] = 1; m_win[s] = 1; end
        else if (m_c[s] == max_r[s]) begin m_done[s] = 1; m_win[s] = 0; end
      end
    end
  endtask

  task automatic chk_all(input int s, input string ctx);
    logic [31:0] obs [8];
    if (s == 0) begin
      obs[0] = {31'b0, if0.play_ready};
      obs[1] = {31'b0, if0.result_valid};
      obs[2] = {30'b0, if0.round_result};
      obs[3] = {28'b0, if0.a_score};
      obs[4] = {28'b0, if0.b_score};
      obs[5] = {28'b0, if0.round_cnt};
      obs[6] = {31'b0, if0.match_done};
      obs[7] = {30'b0, if0.winner};
    end else begin
      obs[0] = {31'b0, if1.play_ready};
      obs[1] = {31'b0, if1.result_valid};
      obs[2] = {30'b0, if1.round_result};
      obs[3] = {28'b0, if1.a_score};
      obs[4] = {28'b0, if1.b_score};
      obs[5] = {28'b0, if1.round_cnt};
      obs[6] = {31'b0, if1.match_done};
      obs[7] = {30'b0, if1.winner};
    end
    chk($sformatf("%s/d%0d/play_ready", ctx, s),   obs[0], 32'(!m_done[s]));
    chk($sformatf("%s/d%0d/result_valid", ctx, s), obs[1], 32'(m_rv[s]));
    chk($sformatf("%s/d%0d/round_result", ctx, s), obs[2], 32'(m_res[s]));
    chk($sformatf("%s/d%0d/a_score", ctx, s),      obs[3], 32'(m_a[s]));
    chk($sformatf("%s/d%0d/b_score", ctx, s),      obs[4], 32'(m_b[s]));
    chk($sformatf("%s/d%0d/round_cnt", ctx, s),    obs[5], 32'(m_c[s]));
    chk($sformatf("%s/d%0d/match_done", ctx, s),   obs[6], 32'(m_done[s]));
    chk($sformatf("%s/d%0d/winner", ctx, s),       obs[7], 32'(m_win[s]));
  endtask

  task automatic idle();
    if0.new_match = 0; if0.play_valid = 0; if0.a_move = 3'b000; if0.b_move = 3'b000;
    if1.new_match = 0; if1.play_valid = 0; if1.a_move = 3'b000; if1.b_move = 3'b000;
  endtask

  // One clock: drive at the falling edge, check 1 time unit after the rising edge.
  task automatic step(input int s, input bit nm, input bit pv,
                      input logic [2:0] a, input logic [2:0] b, input string ctx);
    @(negedge clk);
    idle();
    if (s == 0) begin
      if0.new_match = nm; if0.play_valid = pv; if0.a_move = a; if0.b_move = b;
    end else begin
      if1.new_match = nm; if1.play_valid = pv; if1.a_move = a; if1.b_move = b;
    end
    @(posedge clk);
    #1;
    model_step(s, nm, pv, a, b);
    m_rv[1-s] = 0;
    chk_all(s, ctx);
  endtask

  function automatic logic [2:0] rand_move();
    case ($urandom_range(0, 7))
      0, 1:    return 3'b100;
      2, 3:    return 3'b010;
      4, 5:    return 3'b001;
      default: return 3'($urandom_range(0, 7));
    endcase
  endfunction

  initial begin
    idle();
    reset_model();
    rst = 1'b1;
    #12;
    chk_all(0, "reset");
    chk_all(1, "reset");
    @(negedge clk);
    rst = 1'b0;

    // A wins 2-0, then a third request is ignored.
    step(0, 0, 1, 3'b100, 3'b001, "a20_r1");
    step(0, 0, 1, 3'b010, 3'b100, "a20_r2");
    step(0, 0, 1, 3'b100, 3'b001, "a20_ignored");

    // Invalid then valid.
    step(0, 1, 0, 3'b000, 3'b000, "clear1");
    step(0, 0, 1, 3'b011, 3'b100, "invalid");
    step(0, 0, 1, 3'b001, 3'b010, "valid_after_invalid");

    // new_match beats a simultaneous round; next cycle a round is taken.
    step(0, 1, 1, 3'b100, 3'b001, "prio");
    step(0, 0, 1, 3'b010, 3'b010, "after_prio");

    // Draw with MAX_ROUNDS = 3.
    step(1, 1, 0, 3'b000, 3'b000, "clear_d1");
    step(1, 0, 1, 3'b100, 3'b100, "draw_r1");
    step(1, 0, 1, 3'b100, 3'b100, "draw_r2");
    step(1, 0, 1, 3'b100, 3'b100, "draw_r3");
    step(1, 0, 1, 3'b100, 3'b001, "draw_ignored");

    // Win on the MAX_ROUNDS round counts as a win.
    step(1, 1, 0, 3'b000, 3'b000, "clear_d1b");
    step(1, 0, 1, 3'b100, 3'b010, "last_r1");
    step(1, 0, 1, 3'b010, 3'b010, "last_r2");
    step(1, 0, 1, 3'b100, 3'b010, "last_r3");

    // Randomised traffic on both instances.
    for (int i = 0; i < 600; i++) begin
      int  s;
      bit  nm;
      bit  pv;
      s  = int'($urandom_range(0, 1));
      nm = ($urandom_range(0, 19) == 0);
      pv = ($urandom_range(0, 3) != 0);
      step(s, nm, pv, rand_move(), rand_move(), "rand");
    end

    // Asynchronous reset mid-match, checked before the next edge.
    step(0, 1, 0, 3'b000, 3'b000, "pre_rst_clear");
    step(0, 0, 1, 3'b100, 3'b001, "pre_rst_round");
    #2;
    rst = 1'b1;
    #1;
    reset_model();
    chk_all(0, "async_rst");
    chk_all(1, "async_rst");
    @(negedge clk);
    idle();
    rst = 1'b0;
    step(0, 0, 1, 3'b001, 3'b100, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rps_match.md
# rps_match

Registered best-of-N rock-paper-scissors match controller. It accepts one pair of one-hot moves per round through a valid/ready handshake and classifies each round. It keeps per-player scores and a round counter, and declares a match winner or draw. It sits above the combinational per-round win decode and is what a game front-end or display driver talks to.

## Interface
- `WIN_ROUNDS`, default 2: score a player must reach to win the match. Range is 1 to 2^CNT_W-1.
- `MAX_ROUNDS`, default 9: counted rounds after which the match ends as a draw if nobody has won. Range is WIN_ROUNDS to 2^CNT_W-1.
- `CNT_W`, default 4: width of the score and round counters.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `new_match`  in  1  synchronous clear of the match; pulse.
- `play_valid`  in  1  round request; `a_move` and `b_move` are sampled when `play_valid && play_ready`.
- `a_move`  in  3  player A move, one-hot: 100 = rock, 010 = paper, 001 = scissors.
- `b_move`  in  3  player B move, same encoding.
- `play_ready`  out  1  high while in PLAY.
- `result_valid`  out  1  one-cycle pulse marking `round_result` as fresh.
- `round_result`  out  2  result of the last round: 00 = tie, 10 = A wins, 01 = B wins, 11 = invalid move.
- `a_score`  out  CNT_W  player A rounds won.
- `b_score`  out  CNT_W  player B rounds won.
- `round_cnt`  out  CNT_W  counted rounds, i.e. ties plus decisive rounds.
- `match_done`  out  1  high while in DONE.
- `winner`  out  2  10 = A, 01 = B, 00 = draw or match not done.

## Operation
- States: PLAY and DONE. Reset enters PLAY.
- **Accepted round in PLAY** (`play_valid` high, `new_match` low):
  - **Invalid move:** either move is not exactly one-hot (000, 011, 111, ...). `round_result` = 11. Scores and `round_cnt` do not change.
  - **A wins:** the pairs are rock/scissors, paper/rock and scissors/paper. `a_score`+1, `round_cnt`+1, `round_result` = 10.
  - **B wins:** the mirror pairs. `b_score`+1, `round_cnt`+1, `round_result` = 01.
  - **Tie:** equal valid moves. `round_cnt`+1, `round_result` = 00.
- **End of match**, evaluated on the updated counts on the same edge:
  - If `a_score` = WIN_ROUNDS, go to DONE with `winner` = 10. Same for B with `winner` = 01. Only one player can score per round, so the two cannot occur together.
  - Otherwise, if `round_cnt` = MAX_ROUNDS, go to DONE with `winner` = 00.
  - A win reached on the MAX_ROUNDS round counts as a win, not a draw.
- **DONE:** `play_valid` is ignored. `result_valid` stays low. Outputs hold.
- **`new_match`**, from either state:
  - On the next edge, scores, `round_cnt`, `winner` and `round_result` clear to 0 and the state becomes PLAY.
  - It has priority over a simultaneous `play_valid`; that round is dropped and `result_valid` stays low.
- Counters can never exceed WIN_ROUNDS or MAX_ROUNDS, because DONE is entered first. No wrap-around is possible.

## Timing
- Every output is registered.
- **Reset values:** `play_ready` = 1, `result_valid` = 0, `round_result` = 00, `a_score` = `b_score` = `round_cnt` = 0, `match_done` = 0, `winner` = 00.
- **Reset mid-match** aborts immediately and asynchronously to the same values. It has priority over everything.
- **Latency:** round accepted at edge N gives `result_valid`, `round_result`, the updated scores and `round_cnt`, `match_done` and `winner` all valid after edge N. They are mutually consistent in the same cycle.
- **Throughput:** one round per cycle. `play_valid` held high in PLAY plays back-to-back rounds. Moves may change every cycle.
- **`play_ready`** drops in the cycle after the deciding round, so a request in that cycle is not accepted.
- **`new_match`:** `play_ready` is high in the cycle after the `new_match` edge, and a round can be accepted that cycle.

## Test plan
- **Reset:** assert `rst` asynchronously mid-cycle. All outputs take reset values before the next edge. `play_ready` = 1.
- **A wins 2-0:** defaults; rounds (100,001) then (010,100). `result_valid` pulses with 10 and 10. `a_score` goes 1 then 2. `match_done` = 1 and `winner` = 10 after the second edge. A third `play_valid` is ignored.
- **Invalid then valid:** (011,100) gives `round_result` = 11 with scores and `round_cnt` at 0. Then (001,010) gives `round_result` = 10, `a_score` = 1, `round_cnt` = 1.
- **Draw:** with MAX_ROUNDS = 3, play three ties (100,100). `round_cnt` = 3, `match_done` = 1, `winner` = 00.
- **Win on last round:** with WIN_ROUNDS = 2 and MAX_ROUNDS = 3, play B win, tie, B win (100,010). `winner` = 01, not a draw.
- **Priority:** `new_match` and `play_valid` with (100,001) in the same cycle. Scores stay 0 and `result_valid` stays 0. Next cycle `play_ready` = 1.
